uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  Synthesizable UART receive stage fed by the serial rx lane and configured from
//  uart_transfer_cfg_s fields (uart_globals_pkg). Oversamples rx and recovers one
//  5-8 bit character per frame, checks parity and stop bits, and presents the character
//  on a valid/ready interface to the downstream consumer (monitor/scoreboard bridge).
// PARAMETERS
//  CHAR_LENGTH   8   max data bits; rx_data width
//  DIV_WIDTH     16  width of baudrate_divisor counter
// PORTS
//  clk               in   1            single clock; all logic on posedge
//  rst               in   1            asynchronous, active-low reset
//  rx                in   1            serial line, idle high, async to clk
//  baudrate_divisor  in   DIV_WIDTH    clk cycles per oversample tick
//  uart_type         in   4            data bits, uart_type_e (5..8; 0 = no transfer)
//  oversampling_bits in   4            ticks per bit, oversampling_e (2,4,6,8)
//  parity_en         in   1            1 = parity bit present after data
//  parity_scheme     in   1            parity_e: 0 EVEN, 1 ODD
//  stop_bit          in   2            stop_bit_e: 1 ONE, 0 ONE_HALF, 2 TWO
//  msb_first         in   1            shift_direction_e: 1 = first data bit is MSB
//  rx_data           out  CHAR_LENGTH  received char, right-justified, upper bits 0
//  rx_valid          out  1            rx_data held valid
//  rx_ready          in   1            consumer accepts when rx_valid && rx_ready
//  parity_err        out  1            qualifies rx_data; valid with rx_valid
//  framing_err       out  1            qualifies rx_data; any sampled stop bit was 0
//  overrun_err       out  1            1-clk pulse: char completed while output full
//  busy              out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; tick and bit counters 0; sync flops 1.
//  rx passes a 2-flop synchronizer (reset value 1); all sampling uses the synced value.
//  Tick: tick pulses every max(baudrate_divisor,1) clks; the counter runs only when busy
//   and restarts at start detect.
//  Config: latched at start detect; changes mid-frame take effect from the next frame.
//   Illegal config (uart_type not 5..8, or oversampling_bits not 2/4/6/8) -> remain IDLE.
//  FSM (uart_fsm_state_e encoding):
//   IDLE: a synced 1->0 edge with legal config -> START.
//   START: sample at tick OS/2. 1 = false start -> IDLE with no output. 0 -> DATA0.
//   DATAn: sample every OS ticks thereafter. Shift LSB- or MSB-first per msb_first.
//    After uart_type bits -> PARITY if parity_en, else STOP.
//   PARITY: expected bit = ^data for EVEN, ~^data for ODD. Mismatch sets parity_err.
//   STOP: sample. 0 sets framing_err.
//    ONE -> complete.
//    TWO -> STOP_2 (sample again, OR into framing_err) -> complete.
//    ONE_HALF -> STOP_1_5 (wait OS/2 ticks, no sample) -> complete.
//  Complete: next clk load rx_data/errs and set rx_valid; FSM -> IDLE. The next start edge
//   is honoured immediately, including in the same clk.
//  Handshake: rx_valid stays high, with data and errs stable, until rx_valid && rx_ready.
//   Then the next clk clears rx_valid unless a new char completes that same clk (load).
//   Char completes while rx_valid && !rx_ready: new char dropped, old kept, overrun_err
//   pulses for 1 clk.
//  Latency: rx_valid rises 1 clk after the final stop sample tick (after the OS/2 wait for
//   ONE_HALF).
//  rst deassert mid-frame: the frame is lost. The FSM waits for a fresh 1->0 edge; a line
//   already low at reset release is not a start until it returns high.
// TESTING
//  T1 div=4, OS=8, 8N1, LSB, rx=0xA5 -> rx_data=0xA5, no errs; rx_valid 1 clk after stop
//     sample (start edge + 9.5*32 clks +sync).
//  T2 7-bit, EVEN parity, MSB, 0x5A, correct then flipped parity bit -> rx_data=0x5A;
//     parity_err 0 then 1.
//  T3 8N2 0x3C, second stop driven 0 -> rx_data=0x3C, framing_err=1.
//  T4 rx low glitch of 2*div clks in IDLE -> false start, no rx_valid, busy returns 0.
//  T5 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once;
//     ready=1 accepts 0x11.
//  T6 rst asserted mid-DATA3, released with rx high, then frame 5-bit 0x15 ONE_HALF ->
//     rx_data=0x15, no errs.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes and oversamples the rx line and recovers
// one 5..8 bit character per frame. Parity and stop bits are checked, and the result
// is presented on a valid/ready interface with a one-clock overrun pulse.
module uart_rx_deserializer #(
  parameter int CHAR_LENGTH = 8,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic [DIV_WIDTH-1:0]   baudrate_divisor,
  input  logic [3:0]             uart_type,
  input  logic [3:0]             oversampling_bits,
  input  logic                   parity_en,
  input  logic                   parity_scheme,
  input  logic [1:0]             stop_bit,
  input  logic                   msb_first,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   framing_err,
  output logic                   overrun_err,
  output logic                   busy
);

  localparam int IDX_W = (CHAR_LENGTH > 1) ? $clog2(CHAR_LENGTH) : 1;
  localparam logic [3:0] MAX_TYPE = 4'(CHAR_LENGTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_STOP_2   = 3'd5,
    ST_STOP_1_5 = 3'd6
  } uart_fsm_state_e;

  uart_fsm_state_e        state_reg;
  logic                   rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [1:0]             fill_reg;
  logic [DIV_WIDTH-1:0]   div_cnt_reg, div_m1_reg;
  logic [3:0]             tick_cnt_reg, bit_cnt_reg;
  logic [3:0]             len_reg, os_reg;
  logic                   par_en_reg, par_odd_reg, msb_reg;
  logic [1:0]             stop_reg;
  logic [CHAR_LENGTH-1:0] shift_reg;
  logic                   perr_reg, ferr_reg, complete_reg;

  logic                   line_fall, cfg_legal, start_det, tick, bit_done;
  logic [3:0]             target;
  logic [DIV_WIDTH-1:0]   div_m1_next;
  logic [IDX_W-1:0]       bit_idx;

  // Two-flop synchronizer plus edge history; fill_reg marks when rx_prev_reg holds
  // a real line sample so a line held low across reset release is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      fill_reg    <= 2'd0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
    end
  end

  assign line_fall = (fill_reg == 2'd3) && rx_prev_reg && !rx_sync_reg;
  assign cfg_legal = (uart_type >= 4'd5) && (uart_type <= MAX_TYPE) &&
                     ((oversampling_bits == 4'd2) || (oversampling_bits == 4'd4) ||
                      (oversampling_bits == 4'd6) || (oversampling_bits == 4'd8));
  assign start_det = (state_reg == ST_IDLE) && line_fall && cfg_legal;
  assign busy      = (state_reg != ST_IDLE);
  assign tick      = busy && (div_cnt_reg == div_m1_reg);
  assign div_m1_next = (baudrate_divisor == '0) ? '0 : baudrate_divisor - 1'b1;
  assign bit_idx   = msb_reg ? IDX_W'(len_reg - 4'd1 - bit_cnt_reg) : IDX_W'(bit_cnt_reg);

  // Ticks per sample point: half a bit for the start bit and the 1.5-stop tail.
  always_comb begin
    target = os_reg;
    if (state_reg == ST_START || state_reg == ST_STOP_1_5) target = {1'b0, os_reg[3:1]};
  end

  assign bit_done = tick && (tick_cnt_reg == target - 4'd1);

  // Oversample tick divider: runs only inside a frame, restarts at start detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (start_det || !busy || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Frame FSM: latches config at start, samples each bit, accumulates errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 4'd0;
      len_reg      <= 4'd0;
      os_reg       <= 4'd0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      msb_reg      <= 1'b0;
      stop_reg     <= 2'd0;
      div_m1_reg   <= '0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      complete_reg <= 1'b0;
    end else begin
      complete_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (start_det) begin
          state_reg    <= ST_START;
          tick_cnt_reg <= 4'd0;
          bit_cnt_reg  <= 4'd0;
          len_reg      <= uart_type;
          os_reg       <= oversampling_bits;
          par_en_reg   <= parity_en;
          par_odd_reg  <= parity_scheme;
          msb_reg      <= msb_first;
          stop_reg     <= stop_bit;
          div_m1_reg   <= div_m1_next;
          shift_reg    <= '0;
          perr_reg     <= 1'b0;
          ferr_reg     <= 1'b0;
        end
      end else begin
        if (tick) tick_cnt_reg <= bit_done ? 4'd0 : tick_cnt_reg + 4'd1;
        if (bit_done) begin
          case (state_reg)
            ST_START: state_reg <= rx_sync_reg ? ST_IDLE : ST_DATA;
            ST_DATA: begin
              shift_reg[bit_idx] <= rx_sync_reg;
              if (bit_cnt_reg == len_reg - 4'd1) begin
                bit_cnt_reg <= 4'd0;
                state_reg   <= par_en_reg ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
            ST_PARITY: begin
              perr_reg  <= rx_sync_reg != ((^shift_reg) ^ par_odd_reg);
              state_reg <= ST_STOP;
            end
            ST_STOP: begin
              ferr_reg <= !rx_sync_reg;
              if (stop_reg == 2'd2) begin
                state_reg <= ST_STOP_2;
              end else if (stop_reg == 2'd0) begin
                state_reg <= ST_STOP_1_5;
              end else begin
                state_reg    <= ST_IDLE;
                complete_reg <= 1'b1;
              end
            end
            ST_STOP_2: begin
              ferr_reg     <= ferr_reg | !rx_sync_reg;
              state_reg    <= ST_IDLE;
              complete_reg <= 1'b1;
            end
            ST_STOP_1_5: begin
              state_reg    <= ST_IDLE;
              complete_reg <= 1'b1;
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (complete_reg) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data     <= shift_reg;
          parity_err  <= perr_reg;
          framing_err <= ferr_reg;
          rx_valid    <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
